// File: rtl/bp_pkg.sv
// Shared definitions for the branch-prediction resolve queue.
//   TAKEN / NOT_TAKEN : direction encodings used by predictor and execute
//   bp_entry_t        : one in-flight prediction {taken, pc} at the default tag width
//   sat_inc           : saturating increment used by the statistics counters
package bp_pkg;

  localparam logic TAKEN     = 1'b1;
  localparam logic NOT_TAKEN = 1'b0;

  localparam int BP_PC_W  = 8;
  localparam int BP_CNT_W = 16;

  typedef struct packed {
    logic               taken;
    logic [BP_PC_W-1:0] pc;
  } bp_entry_t;

  // Returns value + 1, or value unchanged once it has reached max_value.
  // Operands are carried at 32 bits so any counter width up to 32 can use it.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up-counter for branch statistics.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears value
//   inc   : increment request for this cycle
//   value : current count, sticks at all-ones
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CNT_W = BP_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  localparam logic [CNT_W-1:0] MAX_VALUE = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (inc) begin
      value <= CNT_W'(sat_inc(32'(value), 32'(MAX_VALUE)));
    end
  end

endmodule

// File: rtl/bp_resolve_queue.sv
// In-order tracker of in-flight branch predictions between the predictor
// and the execute stage.
//   pred_valid/pred_ready/pred_taken/pred_pc : prediction capture
//   res_valid/res_taken                      : outcome of the oldest branch
//   flush                                    : discard all in-flight entries
//   upd_en/upd_result                        : predictor training strobe
//   mispredict/mispredict_pc                 : mispredict pulse and held PC
//   count/empty/full                         : occupancy
//   underflow_err                            : sticky resolve-while-empty
//   total_cnt/miss_cnt                       : saturating statistics
//
// Handshakes: a prediction is taken on a rising edge where pred_valid and
// pred_ready are both high; pred_ready is a function of registered occupancy
// only, so a pop in the same cycle never frees a slot for a push. A resolve
// is taken where res_valid is high and the queue is non-empty; its results
// appear on upd_en/upd_result/mispredict one cycle later.
module bp_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = BP_PC_W,
  parameter int CNT_W = BP_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  output logic                     pred_ready,
  input  logic                     pred_taken,
  input  logic [PC_W-1:0]          pred_pc,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic                     flush,
  output logic                     upd_en,
  output logic                     upd_result,
  output logic                     mispredict,
  output logic [PC_W-1:0]          mispredict_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     underflow_err,
  output logic [CNT_W-1:0]         total_cnt,
  output logic [CNT_W-1:0]         miss_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic            taken;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count_q;

  logic   push_ok;
  logic   pop_ok;
  logic   miss_now;
  logic   clear_now;
  entry_t head_entry;

  assign empty      = (count_q == '0);
  assign full       = (count_q == (PTR_W+1)'(DEPTH));
  assign pred_ready = !full;
  assign count      = count_q;

  assign head_entry = mem[head];
  assign push_ok    = pred_valid && pred_ready;
  assign pop_ok     = res_valid && !empty;
  assign miss_now   = pop_ok && (head_entry.taken != res_taken);
  // A mispredict makes every younger entry wrong-path, so it empties the
  // queue exactly like an external flush; any same-cycle push is dropped.
  assign clear_now  = flush || miss_now;

  // Entry storage is not reset; only slots between head and tail are read.
  always_ff @(posedge clk) begin
    if (push_ok && !clear_now) begin
      mem[tail] <= '{taken: pred_taken, pc: pred_pc};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (clear_now) begin
      head    <= tail;
      count_q <= '0;
    end else begin
      if (push_ok) tail <= tail + 1'b1;
      if (pop_ok)  head <= head + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Resolve results, registered so they appear the cycle after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_en        <= 1'b0;
      upd_result    <= 1'b0;
      mispredict    <= 1'b0;
      mispredict_pc <= '0;
      underflow_err <= 1'b0;
    end else begin
      upd_en     <= pop_ok;
      mispredict <= miss_now;
      if (pop_ok)                upd_result    <= res_taken;
      if (miss_now)              mispredict_pc <= head_entry.pc;
      if (res_valid && empty)    underflow_err <= 1'b1;
    end
  end

  bp_sat_counter #(.CNT_W(CNT_W)) u_total_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pop_ok),
    .value (total_cnt)
  );

  bp_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_now),
    .value (miss_cnt)
  );

endmodule

// File: tb/tb_bp_resolve_queue.sv
module tb_bp_resolve_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 8;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             pred_valid;
  logic             pred_ready;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_pc;
  logic             res_valid;
  logic             res_taken;
  logic             flush;
  logic             upd_en;
  logic             upd_result;
  logic             mispredict;
  logic [PC_W-1:0]  mispredict_pc;
  logic [2:0]       count;
  logic             empty;
  logic             full;
  logic             underflow_err;
  logic [CNT_W-1:0] total_cnt;
  logic [CNT_W-1:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  bp_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .pred_valid    (pred_valid),
    .pred_ready    (pred_ready),
    .pred_taken    (pred_taken),
    .pred_pc       (pred_pc),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .flush         (flush),
    .upd_en        (upd_en),
    .upd_result    (upd_result),
    .mispredict    (mispredict),
    .mispredict_pc (mispredict_pc),
    .count         (count),
    .empty         (empty),
    .full          (full),
    .underflow_err (underflow_err),
    .total_cnt     (total_cnt),
    .miss_cnt      (miss_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pred_valid = 1'b0; pred_taken = 1'b0; pred_pc = '0;
    res_valid = 1'b0; res_taken = 1'b0; flush = 1'b0;
  endtask

  task automatic push(input logic tk, input logic [PC_W-1:0] pc);
    pred_valid = 1'b1; pred_taken = tk; pred_pc = pc;
    cyc();
    pred_valid = 1'b0;
  endtask

  task automatic resolve(input logic tk);
    res_valid = 1'b1; res_taken = tk;
    cyc();
    res_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    cyc(); cyc();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if ({empty, full, pred_ready} !== 3'b101) begin errors++; $display("FAIL reset_flags got %b exp 101", {empty, full, pred_ready}); end
    checks++; if ({upd_en, upd_result, mispredict, underflow_err} !== 4'b0000) begin errors++; $display("FAIL reset_pulses got %b exp 0000", {upd_en, upd_result, mispredict, underflow_err}); end
    checks++; if (mispredict_pc !== 8'h00 || total_cnt !== 16'd0 || miss_cnt !== 16'd0) begin errors++; $display("FAIL reset_stats pc %h total %0d miss %0d exp 0", mispredict_pc, total_cnt, miss_cnt); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_push();
    push(1'b1, 8'h10);
    push(1'b0, 8'h14);
    push(1'b1, 8'h18);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL push_count got %0d exp 3", count); end
    checks++; if ({empty, full, pred_ready} !== 3'b001) begin errors++; $display("FAIL push_flags got %b exp 001", {empty, full, pred_ready}); end
    checks++; if (upd_en !== 1'b0) begin errors++; $display("FAIL push_no_upd got %b exp 0", upd_en); end
  endtask

  task automatic test_back_to_back();
    res_valid = 1'b1; res_taken = 1'b1;
    cyc();
    checks++; if ({upd_en, upd_result, mispredict} !== 3'b110) begin errors++; $display("FAIL b2b_first got %b exp 110", {upd_en, upd_result, mispredict}); end
    res_taken = 1'b0;
    cyc();
    res_valid = 1'b0;
    checks++; if ({upd_en, upd_result, mispredict} !== 3'b100) begin errors++; $display("FAIL b2b_second got %b exp 100", {upd_en, upd_result, mispredict}); end
    checks++; if (total_cnt !== 16'd2 || miss_cnt !== 16'd0 || count !== 3'd1) begin errors++; $display("FAIL b2b_stats total %0d miss %0d count %0d exp 2 0 1", total_cnt, miss_cnt, count); end
    cyc();
    checks++; if (upd_en !== 1'b0) begin errors++; $display("FAIL b2b_pulse_end got %b exp 0", upd_en); end
  endtask

  task automatic test_flush_only();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_clear count %0d empty %b exp 0 1", count, empty); end
    checks++; if (upd_en !== 1'b0 || total_cnt !== 16'd2) begin errors++; $display("FAIL flush_no_upd upd %b total %0d exp 0 2", upd_en, total_cnt); end
  endtask

  task automatic test_mispredict();
    push(1'b1, 8'h20);
    push(1'b1, 8'h24);
    push(1'b0, 8'h28);
    pred_valid = 1'b1; pred_taken = 1'b1; pred_pc = 8'h30;
    res_valid = 1'b1; res_taken = 1'b0;
    cyc();
    pred_valid = 1'b0; res_valid = 1'b0;
    checks++; if ({upd_en, upd_result, mispredict} !== 3'b101) begin errors++; $display("FAIL miss_pulse got %b exp 101", {upd_en, upd_result, mispredict}); end
    checks++; if (mispredict_pc !== 8'h20) begin errors++; $display("FAIL miss_pc got %h exp 20", mispredict_pc); end
    checks++; if (miss_cnt !== 16'd1 || total_cnt !== 16'd3) begin errors++; $display("FAIL miss_stats miss %0d total %0d exp 1 3", miss_cnt, total_cnt); end
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL miss_clear count %0d exp 0", count); end
    cyc();
    checks++; if (mispredict !== 1'b0 || mispredict_pc !== 8'h20) begin errors++; $display("FAIL miss_hold mis %b pc %h exp 0 20", mispredict, mispredict_pc); end
  endtask

  task automatic test_full();
    push(1'b1, 8'h40);
    push(1'b0, 8'h44);
    push(1'b1, 8'h48);
    push(1'b0, 8'h4c);
    checks++; if ({full, pred_ready, count} !== {1'b1, 1'b0, 3'd4}) begin errors++; $display("FAIL full_flags full %b ready %b count %0d exp 1 0 4", full, pred_ready, count); end
    push(1'b1, 8'h50);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_refuse got %0d exp 4", count); end
    pred_valid = 1'b1; pred_taken = 1'b1; pred_pc = 8'h54;
    res_valid = 1'b1; res_taken = 1'b1;
    cyc();
    pred_valid = 1'b0; res_valid = 1'b0;
    checks++; if (count !== 3'd3 || upd_en !== 1'b1 || mispredict !== 1'b0) begin errors++; $display("FAIL full_pop_push count %0d upd %b mis %b exp 3 1 0", count, upd_en, mispredict); end
    // Remaining entries must be exactly N@44, T@48, N@4c.
    resolve(1'b0);
    resolve(1'b1);
    resolve(1'b0);
    checks++; if (count !== 3'd0 || miss_cnt !== 16'd1 || total_cnt !== 16'd7) begin errors++; $display("FAIL full_drain count %0d miss %0d total %0d exp 0 1 7", count, miss_cnt, total_cnt); end
  endtask

  task automatic test_underflow();
    pred_valid = 1'b1; pred_taken = 1'b1; pred_pc = 8'h5c;
    res_valid = 1'b1; res_taken = 1'b1;
    cyc();
    pred_valid = 1'b0; res_valid = 1'b0;
    checks++; if (upd_en !== 1'b0 || underflow_err !== 1'b1) begin errors++; $display("FAIL underflow upd %b err %b exp 0 1", upd_en, underflow_err); end
    checks++; if (total_cnt !== 16'd7 || count !== 3'd1) begin errors++; $display("FAIL underflow_stats total %0d count %0d exp 7 1", total_cnt, count); end
    resolve(1'b1);
    cyc();
    checks++; if (underflow_err !== 1'b1 || count !== 3'd0 || total_cnt !== 16'd8) begin errors++; $display("FAIL underflow_sticky err %b count %0d total %0d exp 1 0 8", underflow_err, count, total_cnt); end
  endtask

  task automatic test_flush_priority();
    push(1'b1, 8'h60);
    push(1'b0, 8'h64);
    flush = 1'b1; res_valid = 1'b1; res_taken = 1'b1;
    cyc();
    flush = 1'b0; res_valid = 1'b0;
    checks++; if ({upd_en, upd_result, mispredict} !== 3'b110) begin errors++; $display("FAIL flushres_pulse got %b exp 110", {upd_en, upd_result, mispredict}); end
    checks++; if (total_cnt !== 16'd9 || count !== 3'd0) begin errors++; $display("FAIL flushres_stats total %0d count %0d exp 9 0", total_cnt, count); end
  endtask

  task automatic test_reset_mid();
    push(1'b1, 8'h70);
    push(1'b1, 8'h74);
    resolve(1'b0);
    checks++; if (mispredict !== 1'b1 || upd_en !== 1'b1) begin errors++; $display("FAIL pre_rst mis %b upd %b exp 1 1", mispredict, upd_en); end
    push(1'b1, 8'h78);
    pred_valid = 1'b1; pred_pc = 8'h7c;
    res_valid = 1'b1; res_taken = 1'b1;
    cyc();
    #1 rst = 1'b1;
    #1;
    checks++; if (upd_en !== 1'b0 || mispredict !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL rst_mid upd %b mis %b count %0d exp 0 0 0", upd_en, mispredict, count); end
    checks++; if ({empty, pred_ready, underflow_err} !== 3'b110 || total_cnt !== 16'd0 || miss_cnt !== 16'd0 || mispredict_pc !== 8'h00) begin errors++; $display("FAIL rst_mid_state flags %b total %0d miss %0d pc %h", {empty, pred_ready, underflow_err}, total_cnt, miss_cnt, mispredict_pc); end
    idle_inputs();
    cyc();
    rst = 1'b0;
    cyc();
    checks++; if (count !== 3'd0 || upd_en !== 1'b0) begin errors++; $display("FAIL post_rst count %0d upd %b exp 0 0", count, upd_en); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_push();
    test_back_to_back();
    test_flush_only();
    test_mispredict();
    test_full();
    test_underflow();
    test_flush_priority();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout reached at %0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
